alu_arbiter: RTL

Shares one 8-bit `alu` instance between NREQ independent requesters. Each requester presents operands and an opcode with a valid/ready handshake. A round-robin arbiter grants one request at a time and runs it through the ALU with registered operands. The result and carry are returned on a shared response bus, with a per-requester response valid. The block sits between the instruction-issue logic and the existing combinational ALU; the ALU needs no modification.

---
 rtl/alu_arb_pkg.sv | 31 +++
 rtl/alu.sv | 37 +++
 rtl/rr_pick.sv | 32 +++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding,
// ALU opcode values and the operand width.
package alu_arb_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Opcodes follow the selection encoding of the existing ALU
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

endpackage

// File: rtl/alu.sv
// Existing 8-bit combinational ALU. CarryOut always reports the carry of A+B,
// whatever operation is selected.
module alu (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       CarryOut
);

    logic [8:0] sum9;

    assign sum9     = {1'b0, A} + {1'b0, B};
    assign CarryOut = sum9[8];

    always_comb begin
        case (ALU_Sel)
            4'd0:    ALU_Out = sum9[7:0];
            4'd1:    ALU_Out = A - B;
            4'd2:    ALU_Out = A * B;
            4'd3:    ALU_Out = (B == 8'h00) ? 8'hFF : A / B;
            4'd4:    ALU_Out = A << 1;
            4'd5:    ALU_Out = A >> 1;
            4'd6:    ALU_Out = {A[6:0], A[7]};
            4'd7:    ALU_Out = {A[0], A[7:1]};
            4'd8:    ALU_Out = A & B;
            4'd9:    ALU_Out = A | B;
            4'd10:   ALU_Out = A ^ B;
            4'd11:   ALU_Out = ~(A | B);
            4'd12:   ALU_Out = ~(A & B);
            4'd13:   ALU_Out = ~(A ^ B);
            4'd14:   ALU_Out = (A > B) ? 8'd1 : 8'd0;
            default: ALU_Out = (A == B) ? 8'd1 : 8'd0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit at or above ptr,
// wrapping around the request vector.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   winner,
    output logic            any_req
);

    logic [GW:0] idx;

    // ptr never exceeds NREQ-1, so a single conditional subtract is enough to wrap
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (GW+1)'(i);
            if (idx >= (GW+1)'(NREQ)) begin
                idx = idx - (GW+1)'(NREQ);
            end
            if (!any_req && req[idx[GW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// registered operands, registered result held until the owner accepts it.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ALU_W-1:0] req_a,
    input  logic [NREQ*ALU_W-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_sel,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [ALU_W-1:0]      resp_data,
    output logic                  resp_carry,
    output logic                  busy,
    output logic [GW-1:0]         grant_id
);

    state_t             state_q, state_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [ALU_W-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         sel_q, sel_d;
    logic [ALU_W-1:0]   resp_data_q, resp_data_d;
    logic               resp_carry_q, resp_carry_d;

    logic [GW-1:0]      winner;
    logic               any_req;
    logic [ALU_W-1:0]   alu_out;
    logic               alu_carry;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    alu u_alu (
        .A        (a_q),
        .B        (b_q),
        .ALU_Sel  (sel_q),
        .ALU_Out  (alu_out),
        .CarryOut (alu_carry)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        resp_data_d  = resp_data_q;
        resp_carry_d = resp_carry_q;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready[winner] = 1'b1;
                    a_d        = req_a[ALU_W*int'(winner) +: ALU_W];
                    b_d        = req_b[ALU_W*int'(winner) +: ALU_W];
                    sel_d      = req_sel[4*int'(winner) +: 4];
                    grant_id_d = winner;
                    rr_ptr_d   = (winner == GW'(NREQ-1)) ? '0 : winner + 1'b1;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_data_d  = alu_out;
                resp_carry_d = alu_carry;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready[grant_id_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == S_RESP) begin
            resp_valid[grant_id_q] = 1'b1;
        end
    end

    assign resp_data  = resp_data_q;
    assign resp_carry = resp_carry_q;
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            resp_data_q  <= resp_data_d;
            resp_carry_q <= resp_carry_d;
        end
    end

endmodule
